// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA raster timing generator.
//   - vga_state_e   : run-control state (IDLE / RUN / DRAIN)
//   - DEF_*         : 640x480@60 default timing constants
//   - axis_total()  : total length of one axis (active + porches + sync)
// -----------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // stopped, counters parked at (0,0), outputs blanked
        RUN   = 2'd1,   // free-running raster
        DRAIN = 2'd2    // stop requested, finishing the current frame
    } vga_state_e;

    // 640x480@60 (25.175 MHz pixel clock) timing
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CNT_W    = 10;
    localparam int DEF_PIX_DIV  = 4;

    // Length of one axis in pixels (horizontal) or lines (vertical).
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// -----------------------------------------------------------------------------
// vga_axis_cnt
// One raster axis: a wrap-around counter 0 .. TOTAL-1 plus decodes of the
// value it is about to take, so the parent can register the decodes on the
// same edge as the count and keep all outputs skew-free.
//
// Ports
//   clk, rst    : clock, asynchronous active-high reset (count -> 0)
//   inc         : advance by one, wrapping TOTAL-1 -> 0
//   clr         : force the count to 0 (wins over inc)
//   cnt         : current (registered) count
//   wrap        : current count is TOTAL-1 (next inc wraps)
//   nxt_active  : next count lies in the active region
//   nxt_sync    : next count lies in the sync pulse window
// -----------------------------------------------------------------------------
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             nxt_active,
    output logic             nxt_sync
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    // Region bounds are one bit wider than the count so that a window ending
    // exactly at TOTAL (no back porch) is still representable.
    localparam logic [CNT_W:0] ACT_END  = (CNT_W+1)'(ACTIVE);
    localparam logic [CNT_W:0] SYNC_BEG = (CNT_W+1)'(ACTIVE + FP);
    localparam logic [CNT_W:0] SYNC_END = (CNT_W+1)'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   cnt_d_ext;

    assign wrap = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    assign cnt_d_ext  = {1'b0, cnt_d};
    assign nxt_active = (cnt_d_ext < ACT_END);
    assign nxt_sync   = (cnt_d_ext >= SYNC_BEG) && (cnt_d_ext < SYNC_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator. Advances one pixel per tick,
// produces sync pulses, an active-video flag, pixel coordinates and
// line/frame start strobes. A run/stop control always stops on a frame
// boundary.
//
// Build option
//   VGA_PIX_DIV_EN : when defined, the tick comes from an internal modulo-
//                    PIX_DIV clock divider and pix_en is ignored. When not
//                    defined, tick = pix_en and no divider is built.
//
// Ports
//   clk          : system clock (single domain)
//   rst          : asynchronous active-high reset
//   en           : run request, sampled on ticks
//   pix_en       : pixel tick / clock enable
//   hsync, vsync : sync outputs, active level HS_POL / VS_POL
//   valid        : (h_cnt, v_cnt) is inside the active area
//   h_cnt, v_cnt : current pixel coordinates
//   line_start   : one-clk strobe when h becomes 0
//   frame_start  : one-clk strobe when (h,v) becomes (0,0) while running
//   dbg_state    : current run-control state
//
// Handshake: there is no valid/ready pair here; valid is a pure decode of the
// coordinates presented in the same cycle and carries no back-pressure.
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int PIX_DIV  = DEF_PIX_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             valid,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             line_start,
    output logic             frame_start,
    output vga_state_e       dbg_state
);

    // -------------------------------------------------------------------------
    // Pixel tick
    // -------------------------------------------------------------------------
    logic tick;

`ifdef VGA_PIX_DIV_EN
    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div_q;

    // Tick is raised while the divider sits on its last value, so the first
    // tick is sampled by the PIX_DIV-th edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign tick = (div_q == DIV_LAST);

    logic unused_pix_en;
    assign unused_pix_en = pix_en;
`else
    assign tick = pix_en;

    logic unused_pix_div;
    assign unused_pix_div = (PIX_DIV > 1);
`endif

    // -------------------------------------------------------------------------
    // Axis counters
    // -------------------------------------------------------------------------
    logic h_inc, h_clr, h_wrap, h_nxt_active, h_nxt_sync;
    logic v_inc, v_clr, v_wrap, v_nxt_active, v_nxt_sync;

    vga_axis_cnt #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CNT_W  (CNT_W)
    ) u_h_axis (
        .clk        (clk),
        .rst        (rst),
        .inc        (h_inc),
        .clr        (h_clr),
        .cnt        (h_cnt),
        .wrap       (h_wrap),
        .nxt_active (h_nxt_active),
        .nxt_sync   (h_nxt_sync)
    );

    vga_axis_cnt #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CNT_W  (CNT_W)
    ) u_v_axis (
        .clk        (clk),
        .rst        (rst),
        .inc        (v_inc),
        .clr        (v_clr),
        .cnt        (v_cnt),
        .wrap       (v_wrap),
        .nxt_active (v_nxt_active),
        .nxt_sync   (v_nxt_sync)
    );

    // -------------------------------------------------------------------------
    // Run-control FSM
    // -------------------------------------------------------------------------
    vga_state_e state_q;
    vga_state_e state_d;
    logic       frame_end;
    logic       ls_set;
    logic       fs_set;
    logic       running_d;

    assign frame_end = h_wrap && v_wrap;

    always_comb begin
        state_d = state_q;
        h_inc   = 1'b0;
        h_clr   = 1'b0;
        v_inc   = 1'b0;
        v_clr   = 1'b0;
        ls_set  = 1'b0;
        fs_set  = 1'b0;

        case (state_q)
            IDLE: begin
                // Counters stay parked at (0,0). Leaving IDLE presents (0,0)
                // itself rather than advancing past it.
                h_clr = 1'b1;
                v_clr = 1'b1;
                if (tick && en) begin
                    state_d = RUN;
                    ls_set  = 1'b1;
                    fs_set  = 1'b1;
                end
            end

            RUN, DRAIN: begin
                if (tick) begin
                    if ((state_q == DRAIN) && !en && frame_end) begin
                        // Frame finished while draining: park at (0,0).
                        // h still becomes 0 so line_start fires, but this
                        // is not the start of a displayed frame.
                        state_d = IDLE;
                        h_clr   = 1'b1;
                        v_clr   = 1'b1;
                        ls_set  = 1'b1;
                    end else begin
                        state_d = en ? RUN : DRAIN;
                        h_inc   = 1'b1;
                        v_inc   = h_wrap;
                        ls_set  = h_wrap;
                        fs_set  = frame_end;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                h_clr   = 1'b1;
                v_clr   = 1'b1;
            end
        endcase
    end

    assign running_d = (state_d != IDLE);

    // -------------------------------------------------------------------------
    // Registered outputs: decoded from the next coordinates so they line up
    // with the counter registers on the same edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            valid       <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid       <= running_d && h_nxt_active && v_nxt_active;
            hsync       <= (running_d && h_nxt_sync) ? HS_POL : ~HS_POL;
            vsync       <= (running_d && v_nxt_sync) ? VS_POL : ~VS_POL;
            // Set only on tick edges, so they drop on the next clk edge
            // however sparse the ticks are.
            line_start  <= ls_set;
            frame_start <= fs_set;
        end
    end

    assign dbg_state = state_q;

endmodule
